// File: rtl/rxd_ctrl.sv
// rxd_ctrl: UART 8N1 receive controller that sits around rxd_clk.
// It synchronises the serial line, detects the start edge, and raises rx_start.
// It shifts in the frame on each mid-bit sample strobe.
// It ends the frame with rx_done plus rx_valid or frame_err.
// Optional even-parity bit between data and stop: define RXD_PARITY_CHECK_EN.
// With the macro undefined the frame is plain 8N1 and parity_err is tied low.

module rxd_ctrl #(
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rxd,
    input  logic                 sample_clk,
    output logic                 rx_start,
    output logic                 rx_done,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 rx_busy
);

    localparam int CW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    logic                 sync1_q;
    logic                 sync2_q;
    logic                 delay_q;
    logic                 sampleDly_q;
    logic                 falling;
    logic                 sampleHit;

    state_t               state_q;
    state_t               state_d;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] shift_d;
    logic [DATA_BITS-1:0] rxData_q;
    logic [DATA_BITS-1:0] rxData_d;
    logic [CW-1:0]        count_q;
    logic [CW-1:0]        count_d;
    logic                 rxStart_q;
    logic                 rxStart_d;
    logic                 rxDone_q;
    logic                 rxDone_d;
    logic                 rxValid_q;
    logic                 rxValid_d;
    logic                 frameErr_q;
    logic                 frameErr_d;
    logic                 busy_q;
`ifdef RXD_PARITY_CHECK_EN
    logic                 parityBad_q;
    logic                 parityBad_d;
    logic                 parityErr_q;
    logic                 parityErr_d;
`endif

    // Line synchroniser, edge-delay flop and sample-strobe history; line idles high out of reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            delay_q     <= 1'b1;
            sampleDly_q <= 1'b0;
        end else begin
            sync1_q     <= rxd;
            sync2_q     <= sync1_q;
            delay_q     <= sync2_q;
            sampleDly_q <= sample_clk;
        end
    end

    assign falling   = delay_q & ~sync2_q;
    assign sampleHit = sample_clk & ~sampleDly_q;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: frames advance only on a sample strobe rising edge
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (falling) begin
                    state_d = START;
                end
            end
            START: begin
                if (sampleHit) begin
                    state_d = sync2_q ? IDLE : DATA;
                end
            end
            DATA: begin
                if (sampleHit && (count_q == LAST_BIT)) begin
`ifdef RXD_PARITY_CHECK_EN
                    state_d = PARITY;
`else
                    state_d = STOP;
`endif
                end
            end
            PARITY: begin
                if (sampleHit) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (sampleHit) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output and datapath next values; every pulse is registered one cycle after its cause
    always_comb begin
        rxStart_d  = 1'b0;
        rxDone_d   = 1'b0;
        rxValid_d  = 1'b0;
        frameErr_d = 1'b0;
        shift_d    = shift_q;
        count_d    = count_q;
        rxData_d   = rxData_q;
`ifdef RXD_PARITY_CHECK_EN
        parityBad_d = parityBad_q;
        parityErr_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                count_d = '0;
`ifdef RXD_PARITY_CHECK_EN
                parityBad_d = 1'b0;
`endif
                if (falling) begin
                    rxStart_d = 1'b1;
                end
            end
            START: begin
                if (sampleHit) begin
                    if (sync2_q) begin
                        rxDone_d = 1'b1;
                    end else begin
                        count_d = '0;
                    end
                end
            end
            DATA: begin
                if (sampleHit) begin
                    shift_d[count_q] = sync2_q;
                    count_d          = count_q + CW'(1);
                end
            end
            PARITY: begin
`ifdef RXD_PARITY_CHECK_EN
                if (sampleHit) begin
                    parityBad_d = (sync2_q != (^shift_q));
                end
`endif
            end
            STOP: begin
                if (sampleHit) begin
                    rxDone_d = 1'b1;
                    if (sync2_q) begin
`ifdef RXD_PARITY_CHECK_EN
                        if (!parityBad_q) begin
                            rxValid_d = 1'b1;
                            rxData_d  = shift_q;
                        end
`else
                        rxValid_d = 1'b1;
                        rxData_d  = shift_q;
`endif
                    end else begin
                        frameErr_d = 1'b1;
                    end
`ifdef RXD_PARITY_CHECK_EN
                    parityErr_d = parityBad_q;
`endif
                end
            end
            default: begin
            end
        endcase
    end

    // Output and datapath registers; busy covers the rx_start cycle through the rx_done cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rxStart_q  <= 1'b0;
            rxDone_q   <= 1'b0;
            rxValid_q  <= 1'b0;
            frameErr_q <= 1'b0;
            busy_q     <= 1'b0;
            shift_q    <= '0;
            count_q    <= '0;
            rxData_q   <= '0;
`ifdef RXD_PARITY_CHECK_EN
            parityBad_q <= 1'b0;
            parityErr_q <= 1'b0;
`endif
        end else begin
            rxStart_q  <= rxStart_d;
            rxDone_q   <= rxDone_d;
            rxValid_q  <= rxValid_d;
            frameErr_q <= frameErr_d;
            busy_q     <= (state_d != IDLE) || rxDone_d;
            shift_q    <= shift_d;
            count_q    <= count_d;
            rxData_q   <= rxData_d;
`ifdef RXD_PARITY_CHECK_EN
            parityBad_q <= parityBad_d;
            parityErr_q <= parityErr_d;
`endif
        end
    end

    assign rx_start  = rxStart_q;
    assign rx_done   = rxDone_q;
    assign rx_valid  = rxValid_q;
    assign frame_err = frameErr_q;
    assign rx_data   = rxData_q;
    assign rx_busy   = busy_q;
`ifdef RXD_PARITY_CHECK_EN
    assign parity_err = parityErr_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_rxd_ctrl.sv
// tb_rxd_ctrl: bench for rxd_ctrl.
// It includes a behavioural stand-in for rxd_clk, which emits mid-bit sample strobes after rx_start.
// A frame-level model predicts every output on every cycle.
// Directed frames carry hand-computed literal expectations.
// Define RXD_PARITY_CHECK_EN to build bench and design with the parity bit.

module tb_rxd_ctrl;

    localparam int DATA_BITS = 8;
`ifdef RXD_PARITY_CHECK_EN
    localparam int PBITS = 1;
`else
    localparam int PBITS = 0;
`endif
    localparam int FRAME_SAMPLES = 1 + DATA_BITS + PBITS + 1;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 rxd = 1'b1;
    logic                 sample_clk = 1'b0;
    logic                 rx_start;
    logic                 rx_done;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 frame_err;
    logic                 parity_err;
    logic                 rx_busy;

    int checks = 0;
    int failures = 0;
    int startCount = 0;
    int doneCount = 0;
    int validCount = 0;
    int frameErrCount = 0;
    int parityErrCount = 0;
    int bitCycles = 16;
    logic [7:0] validLog[$];

    rxd_ctrl #(.DATA_BITS(DATA_BITS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rxd        (rxd),
        .sample_clk (sample_clk),
        .rx_start   (rx_start),
        .rx_done    (rx_done),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .rx_busy    (rx_busy)
    );

    // 100 MHz-style bench clock, 10 time units per cycle
    initial begin
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Stand-in for rxd_clk: half a bit after rx_start, then every bit, a 3-cycle-wide strobe
    initial begin
        bit active;
        int cnt;
        int hold;
        active = 0;
        cnt = 0;
        hold = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                active = 0;
                hold = 0;
                sample_clk = 1'b0;
            end else if (!active) begin
                sample_clk = 1'b0;
                if (rx_start === 1'b1) begin
                    active = 1;
                    cnt = bitCycles / 2;
                    hold = 0;
                end
            end else if (rx_done === 1'b1) begin
                active = 0;
                hold = 0;
                sample_clk = 1'b0;
            end else begin
                cnt--;
                if (cnt == 0) begin
                    cnt = bitCycles;
                    hold = 3;
                end
                sample_clk = (hold != 0);
                if (hold != 0) hold--;
            end
        end
    end

    // Frame-level model and per-cycle compare, evaluated 1 unit after each rising edge
    initial begin
        logic [3:0] lineHist;
        logic [1:0] strobeHist;
        bit active;
        logic bits[$];
        logic [7:0] expData;
        logic [7:0] word;
        logic eStart, eDone, eValid, eFerr, ePerr, eBusy;
        logic stopBit, parityBad;
        lineHist = '1;
        strobeHist = '0;
        active = 0;
        expData = 8'h00;
        forever begin
            @(posedge clk);
            eStart = 1'b0;
            eDone = 1'b0;
            eValid = 1'b0;
            eFerr = 1'b0;
            ePerr = 1'b0;
            if (!rst_n) begin
                lineHist = '1;
                strobeHist = '0;
                active = 0;
                bits.delete();
                expData = 8'h00;
            end else begin
                lineHist = {lineHist[2:0], rxd};
                strobeHist = {strobeHist[0], sample_clk};
                if (!active) begin
                    if (lineHist[3] && !lineHist[2]) begin
                        eStart = 1'b1;
                        active = 1;
                        bits.delete();
                    end
                end else if (strobeHist[0] && !strobeHist[1]) begin
                    bits.push_back(lineHist[2]);
                    if (bits.size() == 1 && lineHist[2]) begin
                        eDone = 1'b1;
                        active = 0;
                    end else if (bits.size() == FRAME_SAMPLES) begin
                        for (int i = 0; i < DATA_BITS; i++) word[i] = bits[1 + i];
                        stopBit = bits[FRAME_SAMPLES - 1];
`ifdef RXD_PARITY_CHECK_EN
                        parityBad = (bits[1 + DATA_BITS] != (^word));
`else
                        parityBad = 1'b0;
`endif
                        eDone = 1'b1;
                        eFerr = !stopBit;
                        ePerr = parityBad;
                        eValid = stopBit && !parityBad;
                        if (eValid) expData = word;
                        active = 0;
                    end
                end
            end
            eBusy = active || eDone;
            #1;
            checkOutput("rx_start", {31'd0, rx_start}, {31'd0, eStart});
            checkOutput("rx_done", {31'd0, rx_done}, {31'd0, eDone});
            checkOutput("rx_valid", {31'd0, rx_valid}, {31'd0, eValid});
            checkOutput("frame_err", {31'd0, frame_err}, {31'd0, eFerr});
            checkOutput("parity_err", {31'd0, parity_err}, {31'd0, ePerr});
            checkOutput("rx_busy", {31'd0, rx_busy}, {31'd0, eBusy});
            checkOutput("rx_data", {24'd0, rx_data}, {24'd0, expData});
            if (rx_start === 1'b1) startCount++;
            if (rx_done === 1'b1) doneCount++;
            if (rx_valid === 1'b1) begin
                validCount++;
                validLog.push_back(rx_data);
            end
            if (frame_err === 1'b1) frameErrCount++;
            if (parity_err === 1'b1) parityErrCount++;
        end
    end

    task automatic driveBit(input logic value);
        rxd = value;
        repeat (bitCycles) @(negedge clk);
    endtask

    task automatic idle(input int cycles);
        rxd = 1'b1;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [7:0] data, input logic parityBit, input logic stopBit);
        driveBit(1'b0);
        for (int i = 0; i < DATA_BITS; i++) driveBit(data[i]);
        if (PBITS == 1) driveBit(parityBit);
        driveBit(stopBit);
    endtask

    // Watchdog so the run always ends
    initial begin
        #(95000 * 10);
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "[TB] watchdog");
    end

    // Directed scenarios
    initial begin
        rst_n = 1'b0;
        rxd = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("reset_rx_data", {24'd0, rx_data}, 32'h0);
        checkOutput("reset_rx_busy", {31'd0, rx_busy}, 32'h0);
        rst_n = 1'b1;
        idle(8);

        // Normal frame at 9600 bps from 50 MHz
        bitCycles = 5208;
        applyStimulus(8'hA5, 1'b0, 1'b1);
        idle(20);
        checkOutput("a5_starts", startCount, 1);
        checkOutput("a5_valids", validCount, 1);
        checkOutput("a5_dones", doneCount, 1);
        checkOutput("a5_ferr", frameErrCount, 0);
        checkOutput("a5_data", {24'd0, rx_data}, 32'hA5);

        // False start: short low glitch, line high again before the first sample
        rxd = 1'b0;
        repeat (1000) @(negedge clk);
        idle(4000);
        checkOutput("fs_starts", startCount, 2);
        checkOutput("fs_dones", doneCount, 2);
        checkOutput("fs_valids", validCount, 1);
        checkOutput("fs_data", {24'd0, rx_data}, 32'hA5);
        checkOutput("fs_busy", {31'd0, rx_busy}, 32'h0);

        // Framing error, then line held low: no new start until it goes high
        bitCycles = 16;
        applyStimulus(8'h3C, 1'b0, 1'b0);
        rxd = 1'b0;
        repeat (200) @(negedge clk);
        checkOutput("fe_ferr", frameErrCount, 1);
        checkOutput("fe_dones", doneCount, 3);
        checkOutput("fe_valids", validCount, 1);
        checkOutput("fe_data", {24'd0, rx_data}, 32'hA5);
        checkOutput("fe_starts_low", startCount, 3);
        idle(40);
        checkOutput("fe_starts_high", startCount, 3);

        // Back-to-back frames with a single stop bit between them
        applyStimulus(8'h00, 1'b0, 1'b1);
        applyStimulus(8'hFF, 1'b0, 1'b1);
        idle(40);
        checkOutput("b2b_starts", startCount, 5);
        checkOutput("b2b_valids", validCount, 3);
        checkOutput("b2b_first", {24'd0, validLog[1]}, 32'h00);
        checkOutput("b2b_second", {24'd0, validLog[2]}, 32'hFF);
        checkOutput("b2b_data", {24'd0, rx_data}, 32'hFF);

        // Reset after the 4th data sample; frame is abandoned without rx_done
        driveBit(1'b0);
        for (int i = 0; i < 4; i++) driveBit(i[0]);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rxd = 1'b1;
        checkOutput("rst_data", {24'd0, rx_data}, 32'h0);
        checkOutput("rst_busy", {31'd0, rx_busy}, 32'h0);
        checkOutput("rst_done", {31'd0, rx_done}, 32'h0);
        idle(200);
        checkOutput("rst_dones", doneCount, 5);
        applyStimulus(8'h5A, 1'b0, 1'b1);
        idle(40);
        checkOutput("post_rst_valids", validCount, 4);
        checkOutput("post_rst_data", {24'd0, rx_data}, 32'h5A);

`ifdef RXD_PARITY_CHECK_EN
        // Parity: 0x07 has three ones, so the even-parity bit is 1
        applyStimulus(8'h07, 1'b1, 1'b1);
        idle(40);
        checkOutput("par_ok_valids", validCount, 5);
        checkOutput("par_ok_perr", parityErrCount, 0);
        checkOutput("par_ok_data", {24'd0, rx_data}, 32'h07);
        applyStimulus(8'h07, 1'b0, 1'b1);
        idle(40);
        checkOutput("par_bad_perr", parityErrCount, 1);
        checkOutput("par_bad_valids", validCount, 5);
        checkOutput("par_bad_dones", doneCount, 8);
`else
        checkOutput("no_parity_errs", parityErrCount, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
